// File: rtl/hazard_stall_unit.sv
// Load-use / multi-cycle FP / redirect hazard control for the front end of the pipeline.
// Controls are combinational from state and inputs (zero latency); an FP op in EXE holds PC, IF/ID and ID/EXE for FP_LATENCY-1 cycles.
module hazard_stall_unit #(
   parameter int FP_LATENCY = 4,
   parameter int CNT_W      = 3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead_EXE,
   input  logic        RegWrite_EXE,
   input  logic [4:0]  Rt_EXE,
   input  logic [4:0]  Rs_ID,
   input  logic [4:0]  Rt_ID,
   input  logic        Uses_Rt_ID,
   input  logic        FP_EXE,
   input  logic        Redirect_EXE,
   output logic        PC_write,
   output logic        IFID_write,
   output logic        IFID_flush,
   output logic        IDEXE_bubble,
   output logic        IDEXE_hold,
   output logic        Busy,
   output logic [15:0] Stall_count
);

   typedef enum logic {RUN = 1'b0, FP_BUSY = 1'b1} state_t;

   // The detection cycle is the first stall cycle, so FP_BUSY lasts FP_LATENCY-2 cycles.
   localparam logic [CNT_W-1:0] BUSY_CYCLES = (FP_LATENCY > 2) ? CNT_W'(FP_LATENCY - 2) : '0;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       stall_count_q, stall_count_d;
   logic              load_use;

   assign load_use = MemRead_EXE & RegWrite_EXE & (Rt_EXE != 5'd0) &
                     ((Rt_EXE == Rs_ID) | (Uses_Rt_ID & (Rt_EXE == Rt_ID)));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      PC_write      = 1'b1;
      IFID_write    = 1'b1;
      IFID_flush    = 1'b0;
      IDEXE_bubble  = 1'b0;
      IDEXE_hold    = 1'b0;
      Busy          = 1'b0;

      unique case (state_q)
         RUN: begin
            if (Redirect_EXE) begin
               IFID_flush   = 1'b1;
               IDEXE_bubble = 1'b1;
            end else if (FP_EXE && (FP_LATENCY > 1)) begin
               PC_write   = 1'b0;
               IFID_write = 1'b0;
               IDEXE_hold = 1'b1;
               if (BUSY_CYCLES != '0) begin
                  state_d = FP_BUSY;
                  cnt_d   = BUSY_CYCLES;
               end
            end else if (load_use) begin
               PC_write     = 1'b0;
               IFID_write   = 1'b0;
               IDEXE_bubble = 1'b1;
            end
         end
         FP_BUSY: begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEXE_hold = 1'b1;
            Busy       = 1'b1;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: state_d = RUN;
      endcase

      // Reset overrides the controls so the front end keeps flowing while state clears.
      if (Reset) begin
         PC_write     = 1'b1;
         IFID_write   = 1'b1;
         IFID_flush   = 1'b0;
         IDEXE_bubble = 1'b0;
         IDEXE_hold   = 1'b0;
         Busy         = 1'b0;
      end

      stall_count_d = stall_count_q;
      if (!PC_write && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign Stall_count = stall_count_q;

endmodule
